// File: rtl/wb_mem_slave.sv
// Pipelined Wishbone B4 slave RAM: fixed-latency in-order responses, ack for in-range
// beats, err for out-of-range beats, and a periodic refresh window that raises stall.
module wb_mem_slave #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int MEM_DEPTH      = 1024,
   parameter int LATENCY        = 2,
   parameter int REFRESH_PERIOD = 64,
   parameter int REFRESH_LEN    = 4
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic                    wb_cyc_i,
   input  logic                    wb_stb_i,
   input  logic                    wb_we_i,
   input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
   input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   output logic                    wb_ack_o,
   output logic                    wb_err_o,
   output logic                    wb_stall_o
);

   localparam int SEL_W       = DATA_WIDTH / 8;
   localparam int IDX_W       = $clog2(MEM_DEPTH);
   localparam int WORD_W      = ADDR_WIDTH - 2;
   localparam int RC_W        = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
   localparam int STALL_START = REFRESH_PERIOD - REFRESH_LEN;
   localparam logic [WORD_W-1:0] DEPTH_WORDS = WORD_W'(MEM_DEPTH);

   typedef struct packed {
      logic                  valid;
      logic                  we;
      logic [IDX_W-1:0]      idx;
      logic [SEL_W-1:0]      sel;
      logic [DATA_WIDTH-1:0] wdata;
      logic                  oor;
   } stage_t;

   stage_t                pipe_q [LATENCY];
   stage_t                pipe_d [LATENCY];
   logic [DATA_WIDTH-1:0] mem_q  [MEM_DEPTH];

   logic [RC_W-1:0]       ref_cnt_q, ref_cnt_d;
   logic                  stall_q, stall_d;
   logic                  ack_q, ack_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] dat_q, dat_d;

   logic [WORD_W-1:0]     word_adr;
   logic                  accept;
   logic                  exit_fire;
   logic                  mem_we;
   stage_t                exit_s;
   logic                  unused_adr_lsb;

   assign word_adr       = wb_adr_i[ADDR_WIDTH-1:2];
   assign unused_adr_lsb = ^wb_adr_i[1:0];
   assign accept         = wb_cyc_i & wb_stb_i & ~stall_q;
   assign exit_s         = pipe_q[LATENCY-1];
   // Dropping cyc at the exit edge suppresses the response and any write commit.
   assign exit_fire      = exit_s.valid & wb_cyc_i;
   assign mem_we         = exit_fire & ~exit_s.oor & exit_s.we;

   // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
   always_comb begin : pipe_next
      pipe_d[0]       = '0;
      pipe_d[0].valid = accept;
      pipe_d[0].we    = wb_we_i;
      pipe_d[0].idx   = word_adr[IDX_W-1:0];
      pipe_d[0].sel   = wb_sel_i;
      pipe_d[0].wdata = wb_dat_i;
      pipe_d[0].oor   = (word_adr >= DEPTH_WORDS);
      for (int i = 1; i < LATENCY; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
      if (!wb_cyc_i) begin
         for (int i = 0; i < LATENCY; i++) begin
            pipe_d[i].valid = 1'b0;
         end
      end
   end

   // Stall is computed from the next count so the registered flag lines up with ref_cnt.
   always_comb begin : refresh_next
      ref_cnt_d = '0;
      stall_d   = 1'b0;
      if (REFRESH_PERIOD > 0) begin
         ref_cnt_d = (ref_cnt_q == RC_W'(REFRESH_PERIOD - 1)) ? '0 : ref_cnt_q + 1'b1;
         stall_d   = (int'(ref_cnt_d) >= STALL_START);
      end
   end

   always_comb begin : resp_next
      ack_d = exit_fire & ~exit_s.oor;
      err_d = exit_fire & exit_s.oor;
      dat_d = dat_q;
      if (ack_d && !exit_s.we) begin
         dat_d = mem_q[exit_s.idx];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         for (int i = 0; i < LATENCY; i++) begin
            pipe_q[i] <= '0;
         end
         ref_cnt_q <= '0;
         stall_q   <= 1'b0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         dat_q     <= '0;
      end else begin
         for (int i = 0; i < LATENCY; i++) begin
            pipe_q[i] <= pipe_d[i];
         end
         ref_cnt_q <= ref_cnt_d;
         stall_q   <= stall_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         dat_q     <= dat_d;
      end
   end

   // NOTE: the storage array has no reset so it maps onto plain RAM; contents power up undefined.
   always_ff @(posedge wb_clk_i) begin
      if (mem_we) begin
         for (int b = 0; b < SEL_W; b++) begin
            if (exit_s.sel[b]) begin
               mem_q[exit_s.idx][b*8 +: 8] <= exit_s.wdata[b*8 +: 8];
            end
         end
      end
   end

   assign wb_dat_o   = dat_q;
   assign wb_ack_o   = ack_q;
   assign wb_err_o   = err_q;
   assign wb_stall_o = stall_q;

endmodule
